// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot geometry and framing state for the 4-channel TDM receiver
package tdm_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with load-to-1, wrap increment, clear and hold
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : set slot to 1 (slot 0 just consumed)
//   i_inc      : advance slot, wrapping 3 -> 0
//   i_clr      : force slot to 0
//   o_slot     : next expected slot
//   o_last     : high while o_slot is the final slot of the frame
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_last
);
    logic [SLOT_W-1:0] r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_slot <= '0;
        else if (i_clr)
            r_slot <= '0;
        else if (i_load)
            r_slot <= SLOT_W'(1);
        else if (i_inc)
            r_slot <= r_slot + SLOT_W'(1);
    end

    assign o_slot = r_slot;
    assign o_last = r_slot == SLOT_W'(NUM_SLOTS - 1);
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a round-robin 4:1 TDM link, one frame -> four channel registers
//   clk, rst_n       : clock, asynchronous active-low reset
//   din, din_valid   : serial beat and its qualifier
//   frame_sync       : marks the current beat as slot 0
//   y0..y3           : channel outputs, updated together once per complete frame
//   frame_valid      : one-cycle pulse when y0..y3 update
//   slot             : next expected slot
//   locked, sync_err : link supervision (lock status, framing-violation pulse)
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [WIDTH-1:0]  y0,
    output logic [WIDTH-1:0]  y1,
    output logic [WIDTH-1:0]  y2,
    output logic [WIDTH-1:0]  y3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);
    tdm_state_t        r_state;
    logic [WIDTH-1:0]  r_sh0, r_sh1, r_sh2;
    logic [WIDTH-1:0]  r_y0, r_y1, r_y2, r_y3;
    logic              r_fv, r_err, r_locked;
    logic [SLOT_W-1:0] w_slot;
    logic              w_last, w_in_lock, w_load, w_inc, w_clr;

    assign w_in_lock = din_valid && r_state == LOCKED && !frame_sync;
    // Any sync beat restarts the frame at slot 1, whether hunting, on time or early.
    assign w_load    = din_valid && frame_sync;
    assign w_inc     = w_in_lock && w_slot != '0;
    // A non-sync beat where slot 0 was expected drops lock.
    assign w_clr     = w_in_lock && w_slot == '0;

    tdm_slot_ctr u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_inc  (w_inc),
        .i_clr  (w_clr),
        .o_slot (w_slot),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
            r_sh0    <= '0;
            r_sh1    <= '0;
            r_sh2    <= '0;
            r_y0     <= '0;
            r_y1     <= '0;
            r_y2     <= '0;
            r_y3     <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_fv  <= 1'b0;
            r_err <= 1'b0;
            if (din_valid) begin
                if (frame_sync) begin
                    r_sh0    <= din;
                    r_state  <= LOCKED;
                    r_locked <= 1'b1;
                    // Early sync: the partial frame is simply abandoned in the shadows.
                    r_err    <= r_state == LOCKED && w_slot != '0;
                end else if (r_state == LOCKED) begin
                    if (w_slot == '0) begin
                        r_err    <= 1'b1;
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end else if (w_last) begin
                        r_y0 <= r_sh0;
                        r_y1 <= r_sh1;
                        r_y2 <= r_sh2;
                        r_y3 <= din;
                        r_fv <= 1'b1;
                    end else if (w_slot == SLOT_W'(1)) begin
                        r_sh1 <= din;
                    end else begin
                        r_sh2 <= din;
                    end
                end
            end
        end
    end

    assign y0          = r_y0;
    assign y1          = r_y1;
    assign y2          = r_y2;
    assign y3          = r_y3;
    assign frame_valid = r_fv;
    assign sync_err    = r_err;
    assign locked      = r_locked;
    assign slot        = w_slot;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed-vector bench for tdm_demux4 at WIDTH=8
module tb_tdm_demux4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] y0, y1, y2, y3;
    logic       frame_valid, locked, sync_err;
    logic [1:0] slot;
    int         n_tot = 0;
    int         n_bad = 0;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic s);
        @(negedge clk);
        din = d;
        frame_sync = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ys();
        return {y0, y1, y2, y3};
    endfunction

    initial begin
        #12;
        chk("rst_y", ys(), 32'h0);
        chk("rst_locked", locked, 0);
        chk("rst_slot", slot, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_err", sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        beat(8'h11, 1);
        chk("lock_locked", locked, 1);
        chk("lock_slot1", slot, 1);
        beat(8'h22, 0);
        beat(8'h33, 0);
        chk("lock_fv_early", frame_valid, 0);
        beat(8'h44, 0);
        chk("lock_fv", frame_valid, 1);
        chk("lock_y", ys(), 32'h11223344);
        chk("lock_slot0", slot, 0);
        idle(1);
        chk("lock_fv_off", frame_valid, 0);
        chk("lock_y_hold", ys(), 32'h11223344);

        beat(8'h77, 0);
        chk("miss_err", sync_err, 1);
        chk("miss_locked", locked, 0);
        chk("miss_y", ys(), 32'h11223344);
        idle(1);
        chk("miss_err_off", sync_err, 0);

        beat(8'hAA, 0);
        chk("hunt_locked_aa", locked, 0);
        chk("hunt_err_aa", sync_err, 0);
        beat(8'hBB, 0);
        chk("hunt_locked_bb", locked, 0);
        beat(8'h01, 1);
        beat(8'h02, 0);
        beat(8'h03, 0);
        beat(8'h04, 0);
        chk("hunt_fv", frame_valid, 1);
        chk("hunt_y", ys(), 32'h01020304);

        beat(8'h11, 1);
        idle(3);
        chk("gap_slot1", slot, 1);
        chk("gap_fv0", frame_valid, 0);
        beat(8'h22, 0);
        idle(3);
        chk("gap_slot2", slot, 2);
        beat(8'h33, 0);
        idle(3);
        chk("gap_slot3", slot, 3);
        chk("gap_y_hold", ys(), 32'h01020304);
        beat(8'h44, 0);
        chk("gap_fv", frame_valid, 1);
        chk("gap_y", ys(), 32'h11223344);
        idle(1);
        chk("gap_fv_off", frame_valid, 0);

        beat(8'h10, 1);
        beat(8'h20, 0);
        chk("early_err_pre", sync_err, 0);
        beat(8'h30, 1);
        chk("early_err", sync_err, 1);
        chk("early_slot", slot, 1);
        chk("early_locked", locked, 1);
        chk("early_y_hold", ys(), 32'h11223344);
        beat(8'h40, 0);
        chk("early_err_off", sync_err, 0);
        beat(8'h50, 0);
        beat(8'h60, 0);
        chk("early_fv", frame_valid, 1);
        chk("early_y", ys(), 32'h30405060);

        beat(8'hA1, 1);
        beat(8'hA2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_y", ys(), 32'h0);
        chk("amid_slot", slot, 0);
        chk("amid_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'h05, 1);
        beat(8'h06, 0);
        beat(8'h07, 0);
        beat(8'h08, 0);
        chk("post_fv", frame_valid, 1);
        chk("post_y", ys(), 32'h05060708);

        beat(8'h09, 1);
        chk("full_fv_gap1", frame_valid, 0);
        beat(8'h0A, 0);
        beat(8'h0B, 0);
        beat(8'h0C, 0);
        chk("full_fv", frame_valid, 1);
        chk("full_y", ys(), 32'h090A0B0C);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Four-channel time-division demultiplexer. It is the receive end of a round-robin 4:1 TDM link.
- A serial beat stream arrives one slot per valid beat, with a frame-sync marker on slot 0. The block distributes beats into four per-channel holding registers.
- All four channel outputs update together once per complete frame.
- Sits between the TDM link and the per-channel consumers. It provides lock status and sync-error flags for link supervision.

Parameters:
- WIDTH, 1, bit width of each beat and of each channel output y0..y3.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  serial beat data.
- din_valid  input  1  beat qualifier; din and frame_sync are sampled only when this is 1.
- frame_sync  input  1  marks the current beat as slot 0.
- y0  output  WIDTH  channel 0 data, registered.
- y1  output  WIDTH  channel 1 data, registered.
- y2  output  WIDTH  channel 2 data, registered.
- y3  output  WIDTH  channel 3 data, registered.
- frame_valid  output  1  one-cycle pulse when y0..y3 are updated.
- slot  output  2  index of the next expected slot.
- locked  output  1  1 while the state is LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low; assertion takes effect immediately regardless of clk.
- Reset values:
  - y0..y3 = 0, frame_valid = 0, sync_err = 0, locked = 0, slot = 0.
  - shadow[0..2] = 0; state = HUNT.
- States:
  - HUNT: searching for frame_sync.
  - LOCKED: tracking slots.
- HUNT:
  - Beats without frame_sync are discarded.
  - On din_valid & frame_sync: shadow[0] <= din, slot <= 1, go to LOCKED, locked <= 1.
- LOCKED, din_valid=1:
  - frame_sync=0 and slot!=0: normal beat.
    - Slots 1..2: shadow[slot] <= din, slot <= slot+1.
    - Slot 3: y0..y2 <= shadow[0..2], y3 <= din, frame_valid <= 1, slot wraps to 0.
  - frame_sync=1 and slot==0: normal start of frame; shadow[0] <= din, slot <= 1.
  - frame_sync=1 and slot!=0 (early sync):
    - sync_err <= 1; the partial frame is dropped and y0..y3 are unchanged.
    - shadow[0] <= din, slot <= 1, stay LOCKED.
  - frame_sync=0 and slot==0 (missed sync):
    - sync_err <= 1; the beat is discarded.
    - slot <= 0, go to HUNT, locked <= 0.
- din_valid=0: all state holds. Gaps of any length between beats are legal.
- Latency:
  - y0..y3 and frame_valid appear in the cycle after the clock edge that samples the slot-3 beat.
  - At full rate (din_valid=1 continuously), frame_valid pulses every 4 cycles.
- Pulses: frame_valid and sync_err are each high for exactly one cycle per event and otherwise 0.
- y0..y3 hold their last value between frames and are never partially updated.
- Reset mid-frame: the partial frame is lost and all outputs return to reset values asynchronously. After release, the block is in HUNT.
- X on din passes through to the captured channel. X on frame_sync or din_valid is out of contract.

Decomposition:
- Package tdm_pkg:
  - NUM_SLOTS = 4; SLOT_W = 2.
  - State enum tdm_state_t with values HUNT and LOCKED.
- One sub-module, tdm_slot_ctr: a 2-bit slot counter with load-to-1, increment-with-wrap, clear and hold controls, plus a last-slot flag (slot==3). The framing FSM and the data/shadow registers stay in tdm_demux4.

Test Plan (WIDTH=8):
- Basic lock: reset, then full-rate beats 0x11(sync), 0x22, 0x33, 0x44 -> locked=1 after the first beat; the cycle after the 4th beat shows y0..y3 = 11, 22, 33, 44 with frame_valid=1 for one cycle.
- Hunt discard: beats 0xAA, 0xBB without sync, then a sync frame 01, 02, 03, 04 -> locked stays 0 during AA/BB; y0..y3 = 01..04 after the frame; AA/BB never appear.
- Gapped beats: same frame as basic lock with 3 idle cycles between beats -> identical y values; exactly one frame_valid pulse; slot holds during gaps.
- Early sync: 10(sync), 20, then 30(sync), 40, 50, 60 -> one sync_err pulse at beat 30; then y0..y3 = 30, 40, 50, 60; the earlier 10/20 frame is dropped.
- Missed sync: a good frame, then a beat 0x77 without sync at slot 0 -> one sync_err pulse; locked=0; y keeps the previous frame.
- Reset mid-frame: rst_n=0 after 2 beats of a frame -> y0..y3=0, slot=0 and locked=0 immediately without a clock edge; the next sync frame decodes correctly.
